seq_player_ctrl: RTL and testbench

Controller that plays one of 2^SEQ_BITS stored LED sequences from the pattern ROM. Selection comes from debounced up/down pushbutton pulses; stepping is timed by the slow tempo tick. The block drives the ROM address, latches each ROM word, holds the LED pattern for that word's duration, and then advances. It sits between the debouncers/tempo divider and the pattern ROM/LED outputs.

---
 rtl/seq_player_ctrl_if.sv | 32 +++
 rtl/seq_player_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_player_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_player_ctrl_if.sv
// Bus between the sequence player and its neighbours: button/tempo pulses and
// ROM data in, ROM address and display state out.
`timescale 1ns/1ps
interface seq_player_ctrl_if #(
  parameter int unsigned SEQ_BITS  = 3,
  parameter int unsigned STEP_BITS = 4,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DUR_BITS  = 4
);
  logic                          seq_up;
  logic                          seq_dn;
  logic                          play_req;
  logic                          step_tick;
  logic [LED_W+DUR_BITS-1:0]     rom_data;
  logic [SEQ_BITS+STEP_BITS-1:0] rom_addr;
  logic [SEQ_BITS-1:0]           seq_num;
  logic [STEP_BITS-1:0]          step_idx;
  logic [LED_W-1:0]              leds;
  logic                          playing;

  // Environment side: debouncers, tempo divider and pattern ROM
  modport master (
    output seq_up, seq_dn, play_req, step_tick, rom_data,
    input  rom_addr, seq_num, step_idx, leds, playing
  );

  // Controller side
  modport slave (
    input  seq_up, seq_dn, play_req, step_tick, rom_data,
    output rom_addr, seq_num, step_idx, leds, playing
  );
endinterface

// File: rtl/seq_player_ctrl.sv
// LED sequence player: selects one of 2^SEQ_BITS ROM sequences, fetches each
// step word, shows its pattern for 'dur' tempo ticks, then advances.
`timescale 1ns/1ps
module seq_player_ctrl #(
  parameter int unsigned SEQ_BITS  = 3,
  parameter int unsigned STEP_BITS = 4,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DUR_BITS  = 4,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic               clk_50,
  input  logic               reset,
  seq_player_ctrl_if.slave   bus
);

  localparam int unsigned WORD_W = LED_W + DUR_BITS;
  localparam int unsigned WAIT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [SEQ_BITS-1:0]  seq_num_q, seq_num_d;
  logic [STEP_BITS-1:0] step_idx_q, step_idx_d;
  logic [LED_W-1:0]     leds_q, leds_d;
  logic [DUR_BITS-1:0]  dur_cnt_q, dur_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 playing_q, playing_d;

  logic                 sel_chg_c;
  logic [LED_W-1:0]     rom_pat_c;
  logic [DUR_BITS-1:0]  rom_dur_c;

  assign rom_pat_c = bus.rom_data[WORD_W-1:DUR_BITS];
  assign rom_dur_c = bus.rom_data[DUR_BITS-1:0];

  // State and datapath registers
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      seq_num_q  <= '0;
      step_idx_q <= '0;
      leds_q     <= '0;
      dur_cnt_q  <= '0;
      wait_cnt_q <= '0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_num_q  <= seq_num_d;
      step_idx_q <= step_idx_d;
      leds_q     <= leds_d;
      dur_cnt_q  <= dur_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      playing_q  <= playing_d;
    end
  end

  // Next-state: step sequencing, then select override, then play/stop override
  always_comb begin
    state_d    = state_q;
    seq_num_d  = seq_num_q;
    step_idx_d = step_idx_q;
    leds_d     = leds_q;
    dur_cnt_d  = dur_cnt_q;
    wait_cnt_d = wait_cnt_q;
    sel_chg_c  = bus.seq_up ^ bus.seq_dn;

    if (bus.seq_up && !bus.seq_dn) begin
      seq_num_d = seq_num_q + SEQ_BITS'(1);
    end else if (bus.seq_dn && !bus.seq_up) begin
      seq_num_d = seq_num_q - SEQ_BITS'(1);
    end

    case (state_q)
      IDLE: begin
      end
      FETCH: begin
        // A single-cycle ROM needs no wait cycles; LATCH lands ROM_LAT after FETCH
        wait_cnt_d = WAIT_W'(ROM_LAT - 1);
        state_d    = (ROM_LAT > 1) ? WAIT : LATCH;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(1)) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (rom_dur_c != '0) begin
          leds_d    = rom_pat_c;
          dur_cnt_d = rom_dur_c;
          state_d   = HOLD;
        end else if (step_idx_q != '0) begin
          step_idx_d = '0;
          state_d    = FETCH;
        end else begin
          leds_d  = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.step_tick) begin
          dur_cnt_d = dur_cnt_q - DUR_BITS'(1);
          if (dur_cnt_q == DUR_BITS'(1)) begin
            step_idx_d = step_idx_q + STEP_BITS'(1);
            state_d    = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new selection restarts at step 0; old pattern stays until the next latch
    if (sel_chg_c) begin
      step_idx_d = '0;
      if (state_q != IDLE) begin
        state_d   = FETCH;
        leds_d    = leds_q;
        dur_cnt_d = dur_cnt_q;
      end
    end

    if (bus.play_req) begin
      if (state_q == IDLE) begin
        state_d = FETCH;
      end else begin
        state_d    = IDLE;
        leds_d     = '0;
        step_idx_d = '0;
      end
    end

    playing_d = (state_d != IDLE);
  end

  assign bus.rom_addr = {seq_num_q, step_idx_q};
  assign bus.seq_num  = seq_num_q;
  assign bus.step_idx = step_idx_q;
  assign bus.leds     = leds_q;
  assign bus.playing  = playing_q;

endmodule

// File: tb/tb_seq_player_ctrl.sv
// Bench for seq_player_ctrl: two instances (ROM_LAT 1 and 3) with behavioural
// ROMs, a tempo generator, and a step-list reference model of playback.
`timescale 1ns/1ps
module tb_seq_player_ctrl;

  logic clk_50;
  logic reset;

  seq_player_ctrl_if if1 ();
  seq_player_ctrl_if if3 ();

  seq_player_ctrl #(.ROM_LAT(1)) dut1 (.clk_50(clk_50), .reset(reset), .bus(if1.slave));
  seq_player_ctrl #(.ROM_LAT(3)) dut3 (.clk_50(clk_50), .reset(reset), .bus(if3.slave));

  int n_pass;
  int n_checks;

  logic [11:0] rom1 [0:127];
  logic [11:0] rom3 [0:127];
  logic [11:0] p1;
  logic [11:0] p2;

  bit tick_en;
  int tick_period;
  int tick_ctr;
  int cur_seq1;

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  // Single-cycle ROM for dut1
  always @(posedge clk_50) if1.rom_data <= rom1[if1.rom_addr];

  // Three-cycle ROM pipeline for dut3
  always @(posedge clk_50) begin
    p1           <= rom3[if3.rom_addr];
    p2           <= p1;
    if3.rom_data <= p2;
  end

  // Tempo generator: updates 1ns after each rising edge
  initial begin
    tick_ctr      = 0;
    if1.step_tick = 1'b0;
    if3.step_tick = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      if (tick_en) begin
        if (tick_ctr >= tick_period - 1) begin
          tick_ctr      = 0;
          if1.step_tick = 1'b1;
          if3.step_tick = 1'b1;
        end else begin
          tick_ctr      = tick_ctr + 1;
          if1.step_tick = 1'b0;
          if3.step_tick = 1'b0;
        end
      end else begin
        tick_ctr      = 0;
        if1.step_tick = 1'b0;
        if3.step_tick = 1'b0;
      end
    end
  end

  // Advance to 2ns after the next rising edge (drive/sample point)
  task automatic cyc();
    @(posedge clk_50);
    #2;
  endtask

  // One-cycle button pulse on the chosen instance
  task automatic press(input int inst, input logic up, input logic dn, input logic pl);
    if (inst == 0) begin
      if1.seq_up = up; if1.seq_dn = dn; if1.play_req = pl;
    end else begin
      if3.seq_up = up; if3.seq_dn = dn; if3.play_req = pl;
    end
    cyc();
    if1.seq_up = 1'b0; if1.seq_dn = 1'b0; if1.play_req = 1'b0;
    if3.seq_up = 1'b0; if3.seq_dn = 1'b0; if3.play_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    // Power-on reset values
    n_checks++; if (if1.leds !== 8'h00) $display("FAIL por_leds: got %h expected 00", if1.leds); else n_pass++;
    n_checks++; if (if1.playing !== 1'b0) $display("FAIL por_playing: got %b expected 0", if1.playing); else n_pass++;
    n_checks++; if (if3.rom_addr !== 7'h00) $display("FAIL por_rom_addr3: got %h expected 00", if3.rom_addr); else n_pass++;
    reset = 1'b0;
    cyc();
    // seq 0 = A5/2, 3C/1, end
    rom1[0] = {8'hA5, 4'd2};
    rom1[1] = {8'h3C, 4'd1};
    rom1[2] = {8'h00, 4'd0};
    tick_en = 1'b0;
    press(0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (if1.leds !== 8'hA5 && n < 50) begin cyc(); n++; end
    n_checks++; if (if1.leds !== 8'hA5) $display("FAIL reset_reach_hold: got %h expected a5", if1.leds); else n_pass++;
    // Assert reset mid-cycle, away from any clock edge
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (if1.leds !== 8'h00) $display("FAIL async_leds: got %h expected 00", if1.leds); else n_pass++;
    n_checks++; if (if1.playing !== 1'b0) $display("FAIL async_playing: got %b expected 0", if1.playing); else n_pass++;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    n_checks++; if (if1.playing !== 1'b0) $display("FAIL post_reset_playing: got %b expected 0", if1.playing); else n_pass++;
    n_checks++; if (if1.rom_addr !== 7'h00) $display("FAIL post_reset_addr: got %h expected 00", if1.rom_addr); else n_pass++;
    // Ticks are ignored in IDLE
    tick_period = 3;
    tick_en = 1'b1;
    repeat (10) cyc();
    tick_en = 1'b0;
    n_checks++; if (if1.leds !== 8'h00 || if1.playing !== 1'b0)
      $display("FAIL idle_ignores_tick: got leds %h playing %b expected 00 0", if1.leds, if1.playing); else n_pass++;
    cur_seq1 = 0;
  endtask

  task automatic test_select();
    int exp_seq;
    exp_seq = cur_seq1;
    for (int i = 0; i < 9; i++) begin
      press(0, 1'b1, 1'b0, 1'b0);
      exp_seq = (exp_seq + 1) % 8;
      n_checks++; if (if1.seq_num !== 3'(exp_seq)) $display("FAIL select_up: got %0d expected %0d", if1.seq_num, exp_seq); else n_pass++;
      n_checks++; if (if1.step_idx !== 4'd0) $display("FAIL select_up_step: got %0d expected 0", if1.step_idx); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      press(0, 1'b0, 1'b1, 1'b0);
      exp_seq = (exp_seq + 7) % 8;
      n_checks++; if (if1.seq_num !== 3'(exp_seq)) $display("FAIL select_dn: got %0d expected %0d", if1.seq_num, exp_seq); else n_pass++;
    end
    press(0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (if1.seq_num !== 3'(exp_seq)) $display("FAIL select_both: got %0d expected %0d", if1.seq_num, exp_seq); else n_pass++;
    n_checks++; if (if1.step_idx !== 4'd0 || if1.playing !== 1'b0)
      $display("FAIL select_both_state: got step %0d playing %b expected 0 0", if1.step_idx, if1.playing); else n_pass++;
    cur_seq1 = exp_seq;
  endtask

  // Play sequence 'seq' and compare nev displayed steps against a step-list model
  task automatic run_play(input int inst, input int seq, input int nev);
    int exp_step[$];
    int exp_pat[$];
    int exp_dur[$];
    int lat, st, d, k, cyc_since, tick_cnt, cur_dur, bound;
    bit in_hold;
    logic [11:0] w;
    logic [7:0] prev_leds, o_leds;
    logic [3:0] prev_step, o_step;
    logic o_tick, o_play;

    lat = (inst == 0) ? 1 : 3;
    st = 0;
    while (exp_step.size() < nev) begin
      w = (inst == 0) ? rom1[seq*16 + st] : rom3[seq*16 + st];
      d = int'(w[3:0]);
      if (d != 0) begin
        exp_step.push_back(st);
        exp_pat.push_back(int'(w[11:4]));
        exp_dur.push_back(d);
        st = (st + 1) % 16;
      end else if (st != 0) begin
        st = 0;
      end else begin
        break;
      end
    end

    tick_period = $urandom_range(10, 16);
    tick_en = 1'b1;
    press(inst, 1'b0, 1'b0, 1'b1);
    o_play    = (inst == 0) ? if1.playing : if3.playing;
    prev_leds = (inst == 0) ? if1.leds : if3.leds;
    prev_step = (inst == 0) ? if1.step_idx : if3.step_idx;
    n_checks++; if (o_play !== 1'b1) $display("FAIL play_start: got %b expected 1", o_play); else n_pass++;

    k = 0; cyc_since = 0; tick_cnt = 0; cur_dur = 0; in_hold = 1'b0;
    bound = nev * 70 + 50;
    for (int n = 0; n < bound && k < nev; n++) begin
      cyc();
      cyc_since++;
      o_leds = (inst == 0) ? if1.leds : if3.leds;
      o_step = (inst == 0) ? if1.step_idx : if3.step_idx;
      o_tick = (inst == 0) ? if1.step_tick : if3.step_tick;
      if (o_step !== prev_step) begin
        if (in_hold) begin
          n_checks++; if (tick_cnt != cur_dur) $display("FAIL hold_ticks: got %0d expected %0d", tick_cnt, cur_dur); else n_pass++;
        end
        in_hold = 1'b0;
        cyc_since = 0;
      end
      if (o_leds !== prev_leds) begin
        n_checks++; if (o_leds !== 8'(exp_pat[k])) $display("FAIL event_leds: got %h expected %h", o_leds, 8'(exp_pat[k])); else n_pass++;
        n_checks++; if (o_step !== 4'(exp_step[k])) $display("FAIL event_step: got %0d expected %0d", o_step, exp_step[k]); else n_pass++;
        n_checks++; if (cyc_since != lat + 1) $display("FAIL fetch_latency: got %0d expected %0d", cyc_since, lat + 1); else n_pass++;
        in_hold = 1'b1;
        tick_cnt = 0;
        cur_dur = exp_dur[k];
        k++;
      end
      if (in_hold && o_tick) tick_cnt++;
      prev_leds = o_leds;
      prev_step = o_step;
    end
    if (k < nev) begin
      n_checks++;
      $display("FAIL play_timeout: got %0d steps expected %0d", k, nev);
    end

    press(inst, 1'b0, 1'b0, 1'b1);
    tick_en = 1'b0;
    o_play = (inst == 0) ? if1.playing : if3.playing;
    o_leds = (inst == 0) ? if1.leds : if3.leds;
    o_step = (inst == 0) ? if1.step_idx : if3.step_idx;
    n_checks++; if (o_play !== 1'b0 || o_leds !== 8'h00 || o_step !== 4'd0)
      $display("FAIL play_stop: got playing %b leds %h step %0d expected 0 00 0", o_play, o_leds, o_step); else n_pass++;
  endtask

  task automatic test_play_basic();
    press(0, 1'b1, 1'b0, 1'b0);
    cur_seq1 = (cur_seq1 + 1) % 8;
    n_checks++; if (if1.seq_num !== 3'(cur_seq1)) $display("FAIL basic_seq: got %0d expected %0d", if1.seq_num, cur_seq1); else n_pass++;
    run_play(0, 0, 5);
  endtask

  task automatic test_empty_seq();
    rom1[32] = {8'h77, 4'd0};
    press(0, 1'b1, 1'b0, 1'b0);
    press(0, 1'b1, 1'b0, 1'b0);
    cur_seq1 = (cur_seq1 + 2) % 8;
    press(0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (if1.rom_addr !== 7'h20) $display("FAIL empty_addr: got %h expected 20", if1.rom_addr); else n_pass++;
    n_checks++; if (if1.playing !== 1'b1) $display("FAIL empty_fetch_playing: got %b expected 1", if1.playing); else n_pass++;
    cyc();
    cyc();
    n_checks++; if (if1.playing !== 1'b0) $display("FAIL empty_idle: got %b expected 0", if1.playing); else n_pass++;
    n_checks++; if (if1.leds !== 8'h00) $display("FAIL empty_leds: got %h expected 00", if1.leds); else n_pass++;
    repeat (5) cyc();
    n_checks++; if (if1.playing !== 1'b0 || if1.rom_addr !== 7'h20)
      $display("FAIL empty_stays_idle: got playing %b addr %h expected 0 20", if1.playing, if1.rom_addr); else n_pass++;
  endtask

  task automatic test_select_during_hold();
    int n;
    rom1[16] = {8'h5A, 4'd3};
    rom1[17] = {8'h00, 4'd0};
    press(0, 1'b0, 1'b1, 1'b0);
    press(0, 1'b0, 1'b1, 1'b0);
    cur_seq1 = (cur_seq1 + 6) % 8;
    tick_period = 10;
    tick_en = 1'b1;
    press(0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (if1.leds !== 8'h3C && n < 200) begin cyc(); n++; end
    tick_en = 1'b0;
    n_checks++; if (if1.leds !== 8'h3C || if1.step_idx !== 4'd1)
      $display("FAIL hold_reach: got leds %h step %0d expected 3c 1", if1.leds, if1.step_idx); else n_pass++;
    press(0, 1'b1, 1'b0, 1'b0);
    cur_seq1 = (cur_seq1 + 1) % 8;
    n_checks++; if (if1.rom_addr !== 7'h10) $display("FAIL hold_sel_addr: got %h expected 10", if1.rom_addr); else n_pass++;
    n_checks++; if (if1.leds !== 8'h3C) $display("FAIL hold_sel_keep: got %h expected 3c", if1.leds); else n_pass++;
    cyc();
    n_checks++; if (if1.leds !== 8'h3C) $display("FAIL hold_sel_keep2: got %h expected 3c", if1.leds); else n_pass++;
    cyc();
    n_checks++; if (if1.leds !== 8'h5A) $display("FAIL hold_sel_new: got %h expected 5a", if1.leds); else n_pass++;
    press(0, 1'b1, 1'b0, 1'b1);
    cur_seq1 = (cur_seq1 + 1) % 8;
    n_checks++; if (if1.playing !== 1'b0 || if1.leds !== 8'h00)
      $display("FAIL sel_play_stop: got playing %b leds %h expected 0 00", if1.playing, if1.leds); else n_pass++;
    n_checks++; if (if1.seq_num !== 3'(cur_seq1) || if1.step_idx !== 4'd0)
      $display("FAIL sel_play_seq: got seq %0d step %0d expected %0d 0", if1.seq_num, if1.step_idx, cur_seq1); else n_pass++;
  endtask

  task automatic test_random_play();
    int r, len;
    for (int it = 0; it < 3; it++) begin
      r = $urandom_range(0, 7);
      len = $urandom_range(2, 16);
      for (int s = 0; s < 16; s++) begin
        if (s < len) rom1[r*16 + s] = {4'(s), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 3))};
        else         rom1[r*16 + s] = {8'($urandom_range(0, 255)), 4'd0};
      end
      while (cur_seq1 != r) begin
        press(0, 1'b1, 1'b0, 1'b0);
        cur_seq1 = (cur_seq1 + 1) % 8;
      end
      n_checks++; if (if1.seq_num !== 3'(r)) $display("FAIL rand_seq: got %0d expected %0d", if1.seq_num, r); else n_pass++;
      run_play(0, r, $urandom_range(len + 2, len + 6));
    end
  endtask

  task automatic test_wrap_lat3();
    for (int s = 0; s < 16; s++) rom3[s] = {4'(s), 4'($urandom_range(1, 15)), 4'd1};
    n_checks++; if (if3.seq_num !== 3'd0) $display("FAIL lat3_seq: got %0d expected 0", if3.seq_num); else n_pass++;
    run_play(1, 0, 20);
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    tick_en = 1'b0;
    tick_period = 10;
    cur_seq1 = 0;
    for (int i = 0; i < 128; i++) begin
      rom1[i] = 12'h000;
      rom3[i] = 12'h000;
    end
    if1.seq_up = 1'b0; if1.seq_dn = 1'b0; if1.play_req = 1'b0;
    if3.seq_up = 1'b0; if3.seq_dn = 1'b0; if3.play_req = 1'b0;
    reset = 1'b1;
    repeat (3) cyc();

    test_reset();
    test_select();
    test_play_basic();
    test_empty_seq();
    test_select_during_hold();
    test_random_play();
    test_wrap_lat3();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
